// File: rtl/md_unit_if.sv
// Handshake and result bundle between the EX stage and the multiply/divide unit.
// The master issues operations; the slave (md_unit) reports busy and the HI/LO registers.
interface md_unit_if;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;

  modport master (output start, md_op, src_a, src_b, input busy, hi, lo);
  modport slave  (input start, md_op, src_a, src_b, output busy, hi, lo);
endinterface

// File: rtl/md_unit.sv
// Multi-cycle multiply/divide unit holding the architectural HI/LO registers.
// Results are formed at the accepting edge and published to HI/LO after a fixed busy period.
module md_unit #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic  clk,
  input  logic  rst_n,
  md_unit_if.slave md
);
  localparam int MAX_CYCLES = (MUL_CYCLES > DIV_CYCLES) ? MUL_CYCLES : DIV_CYCLES;
  localparam int CW = $clog2(MAX_CYCLES) + 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          busy_q;
  logic          div0_q;
  logic [31:0]   hi_q, lo_q, p_hi_q, p_lo_q;

  logic [31:0] p_hi_d, p_lo_d;
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, div_u, mag_q, mag_r, uq, ur;
  logic        accept, b_zero;

  assign accept = md.start && !busy_q;
  assign b_zero = (md.src_b == 32'd0);

  always_comb begin
    prod_s = $signed({{32{md.src_a[31]}}, md.src_a}) * $signed({{32{md.src_b[31]}}, md.src_b});
    prod_u = {32'd0, md.src_a} * {32'd0, md.src_b};
    // Divisors of zero are replaced by one only to keep the divider defined; the result is discarded.
    div_u  = b_zero ? 32'd1 : md.src_b;
    abs_a  = md.src_a[31] ? (32'd0 - md.src_a) : md.src_a;
    abs_b  = md.src_b[31] ? (32'd0 - md.src_b) : md.src_b;
    if (b_zero) abs_b = 32'd1;
    mag_q  = abs_a / abs_b;
    mag_r  = abs_a % abs_b;
    uq     = md.src_a / div_u;
    ur     = md.src_a % div_u;
    p_hi_d = 32'd0;
    p_lo_d = 32'd0;
    case (md.md_op)
      3'd0: {p_hi_d, p_lo_d} = prod_s;
      3'd1: {p_hi_d, p_lo_d} = prod_u;
      3'd2: begin
        // Magnitude division then sign fix-up; 0x80000000 / -1 wraps back to 0x80000000 naturally.
        p_lo_d = (md.src_a[31] ^ md.src_b[31]) ? (32'd0 - mag_q) : mag_q;
        p_hi_d = md.src_a[31] ? (32'd0 - mag_r) : mag_r;
      end
      3'd3: begin
        p_lo_d = uq;
        p_hi_d = ur;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      div0_q  <= 1'b0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      p_hi_q  <= 32'd0;
      p_lo_q  <= 32'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            case (md.md_op)
              3'd0, 3'd1: begin
                p_hi_q  <= p_hi_d;
                p_lo_q  <= p_lo_d;
                div0_q  <= 1'b0;
                cnt_q   <= CW'(MUL_CYCLES);
                busy_q  <= 1'b1;
                state_q <= RUN;
              end
              3'd2, 3'd3: begin
                p_hi_q  <= p_hi_d;
                p_lo_q  <= p_lo_d;
                div0_q  <= b_zero;
                cnt_q   <= CW'(DIV_CYCLES);
                busy_q  <= 1'b1;
                state_q <= RUN;
              end
              3'd4: hi_q <= md.src_a;
              3'd5: lo_q <= md.src_a;
              default: ;
            endcase
          end
        end
        RUN: begin
          cnt_q <= cnt_q - CW'(1);
          if (cnt_q == CW'(1)) begin
            if (!div0_q) begin
              hi_q <= p_hi_q;
              lo_q <= p_lo_q;
            end
            busy_q  <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign md.busy = busy_q;
  assign md.hi   = hi_q;
  assign md.lo   = lo_q;
endmodule

// File: tb/tb_md_unit.sv
// Randomised and directed bench for md_unit against a 64-bit arithmetic reference model.
module tb_md_unit;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_pass = 0;
  int n_total = 0;
  logic [31:0] exp_hi = 32'd0;
  logic [31:0] exp_lo = 32'd0;

  md_unit_if mif ();

  md_unit #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .md    (mif.slave)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Reference: new HI/LO from the architectural rules, plus the busy duration.
  task automatic model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       inout logic [31:0] h, inout logic [31:0] l, output int n);
    longint sa, sb, sp;
    longint unsigned up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    n = 0;
    case (op)
      3'd0: begin sp = sa * sb; h = sp[63:32]; l = sp[31:0]; n = MUL_N; end
      3'd1: begin up = {32'd0, a} * {32'd0, b}; h = up[63:32]; l = up[31:0]; n = MUL_N; end
      3'd2, 3'd3: begin
        n = DIV_N;
        if (b == 32'd0) begin
        end else if (op == 3'd3) begin
          l = a / b; h = a % b;
        end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          l = 32'h8000_0000; h = 32'd0;
        end else begin
          sp = sa / sb; l = sp[31:0];
          sp = sa % sb; h = sp[31:0];
        end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: ;
    endcase
  endtask

  // Called at a falling edge; the request is accepted on the next rising edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    mif.start = 1'b1; mif.md_op = op; mif.src_a = a; mif.src_b = b;
    @(negedge clk);
    mif.start = 1'b0; mif.src_a = $urandom; mif.src_b = $urandom;
  endtask

  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] nh, nl;
    int n;
    nh = exp_hi; nl = exp_lo;
    model(op, a, b, nh, nl, n);
    issue(op, a, b);
    for (int k = 0; k < n; k++) begin
      check("busy_run", mif.busy, 32'd1);
      check("hi_hold", mif.hi, exp_hi);
      check("lo_hold", mif.lo, exp_lo);
      @(negedge clk);
    end
    exp_hi = nh; exp_lo = nl;
    check("busy_done", mif.busy, 32'd0);
    check("hi_result", mif.hi, exp_hi);
    check("lo_result", mif.lo, exp_lo);
    $display("op=%0d a=%h b=%h -> hi=%h lo=%h (exp %h %h)", op, a, b, mif.hi, mif.lo, exp_hi, exp_lo);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    mif.start = 1'b0; mif.md_op = 3'd0; mif.src_a = 32'd0; mif.src_b = 32'd0;
    repeat (2) @(negedge clk);
    check("rst_busy", mif.busy, 32'd0);
    check("rst_hi", mif.hi, 32'd0);
    check("rst_lo", mif.lo, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Start while busy must be ignored: MTLO 0xAA mid-multiply never lands.
    issue(3'd0, 32'h11, 32'h11);
    check("ign_busy", mif.busy, 32'd1);
    @(negedge clk);
    mif.start = 1'b1; mif.md_op = 3'd5; mif.src_a = 32'hAA;
    @(negedge clk);
    mif.start = 1'b0;
    check("ign_lo_mid", mif.lo, 32'd0);
    repeat (3) @(negedge clk);
    check("ign_busy_end", mif.busy, 32'd0);
    check("ign_hi", mif.hi, 32'd0);
    check("ign_lo", mif.lo, 32'h121);
    exp_hi = 32'd0; exp_lo = 32'h121;

    run_op(3'd0, 32'hFFFF_FFFE, 32'd3);
    run_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);   // back-to-back, issued at T0+5
    run_op(3'd2, 32'hFFFF_FFF9, 32'd2);
    run_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    run_op(3'd4, 32'h11, 32'd0);
    run_op(3'd5, 32'h22, 32'd0);
    run_op(3'd3, 32'h1234, 32'd0);
    run_op(3'd2, 32'h8000_0000, 32'd0);
    run_op(3'd6, 32'hDEAD_BEEF, 32'd1);
    run_op(3'd7, 32'hDEAD_BEEF, 32'd1);

    // Asynchronous reset in the 4th busy cycle of a divide.
    run_op(3'd4, 32'h55, 32'd0);
    run_op(3'd5, 32'h66, 32'd0);
    issue(3'd2, 32'd100, 32'd7);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("arst_busy", mif.busy, 32'd0);
    check("arst_hi", mif.hi, 32'd0);
    check("arst_lo", mif.lo, 32'd0);
    exp_hi = 32'd0; exp_lo = 32'd0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    check("post_rst_busy", mif.busy, 32'd0);
    check("post_rst_hi", mif.hi, 32'd0);
    check("post_rst_lo", mif.lo, 32'd0);

    for (int i = 0; i < 60; i++) begin
      run_op(3'($urandom_range(0, 7)), pick(), pick());
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
